// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and a sequential clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data and scoreboard updates to the read ports.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         issue_en,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_pending,
  output logic [DATA_WIDTH-1:0]        a0_value
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   counter, counter_next;
  logic [DEPTH-1:0]        pending, pending_next;
  logic [DATA_WIDTH-1:0]   entry [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      counter <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      pending <= pending_next;
    end
  end

  // Issue is applied after writeback so a same-cycle reissue keeps the newer producer pending.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    pending_next = pending;
    case (state)
      CLEAR: begin
        counter_next = counter + 1'b1;
        if (&counter) state_next = READY;
      end
      READY: begin
        if (clear_req) begin
          state_next   = CLEAR;
          counter_next = '0;
          pending_next = '0;
        end else begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0))
              pending_next[wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
          end
          if (issue_en && (issue_addr != '0)) pending_next[issue_addr] = 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Ascending port order lets the highest-index port's assignment win on an address collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        entry[counter] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            entry[wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((state == READY) && (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = entry[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        rd_pending[p] = pending[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef RF_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            rd_pending[p] = issue_en && (issue_addr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
          end
        end
`endif
      end
    end
  end

  assign ready = (state == READY);

  // Gated during CLEAR so a0 reads zero from reset onward, before the engine reaches x10.
  assign a0_value = (state == READY) ? entry[A0_IDX] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int DEPTH = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic                clear_req;
  logic                ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_pending;
  logic [DW-1:0]       a0_value;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending), .a0_value(a0_value)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // Stimulus as plain per-port values, packed onto the DUT buses in applyStimulus.
  logic          rst, clr, iss;
  logic [AW-1:0] iss_a;
  logic          we [NWR];
  logic [AW-1:0] wa [NWR];
  logic [DW-1:0] wd [NWR];
  logic [AW-1:0] ra [NRD];

  // Reference model: register contents, producer flags, cycles left in the clear sweep.
  logic [DW-1:0] mem  [DEPTH];
  logic          pend [DEPTH];
  int            clr_left;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (clr_left > 0 || a == 0) return '0;
    v = mem[a];
`ifdef RF_BYPASS_EN
    for (int i = 0; i < NWR; i++) if (we[i] && wa[i] == a) v = wd[i];
`endif
    return v;
  endfunction

  function automatic logic expPend(input logic [AW-1:0] a);
    logic v;
    if (clr_left > 0 || a == 0) return 1'b0;
    v = pend[a];
`ifdef RF_BYPASS_EN
    for (int i = 0; i < NWR; i++) if (we[i] && wa[i] == a) v = iss && (iss_a == a);
`endif
    return v;
  endfunction

  task automatic idleInputs();
    rst = 0; clr = 0; iss = 0; iss_a = '0;
    for (int i = 0; i < NWR; i++) begin we[i] = 0; wa[i] = '0; wd[i] = '0; end
    for (int p = 0; p < NRD; p++) ra[p] = '0;
  endtask

  // Drive the current stimulus, let it settle, compare every output against the model.
  task automatic applyStimulus();
    reset = rst; clear_req = clr; issue_en = iss; issue_addr = iss_a;
    for (int i = 0; i < NWR; i++) begin
      wr_en[i] = we[i];
      wr_addr[i*AW +: AW] = wa[i];
      wr_data[i*DW +: DW] = wd[i];
    end
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = ra[p];
    #1;
    checkOutput("ready", {31'b0, ready}, {31'b0, clr_left == 0});
    checkOutput("a0_value", a0_value, (clr_left == 0) ? mem[10] : '0);
    for (int p = 0; p < NRD; p++) begin
      checkOutput($sformatf("rd_data[%0d] x%0d", p, ra[p]), rd_data[p*DW +: DW], expData(ra[p]));
      checkOutput($sformatf("rd_pending[%0d] x%0d", p, ra[p]), {31'b0, rd_pending[p]}, {31'b0, expPend(ra[p])});
    end
  endtask

  // Clock the DUT and advance the model by one cycle using the same stimulus.
  task automatic tick();
    @(posedge clock);
    #1;
    if (rst) begin
      clr_left = DEPTH;
      for (int r = 0; r < DEPTH; r++) pend[r] = 0;
    end else if (clr_left > 0) begin
      mem[DEPTH - clr_left] = '0;
      clr_left--;
    end else if (clr) begin
      clr_left = DEPTH;
      for (int r = 0; r < DEPTH; r++) pend[r] = 0;
    end else begin
      for (int i = 0; i < NWR; i++) if (we[i] && wa[i] != 0) begin
        mem[wa[i]] = wd[i];
        pend[wa[i]] = 0;
      end
      if (iss && iss_a != 0) pend[iss_a] = 1;
    end
  endtask

  task automatic step();
    applyStimulus();
    tick();
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin mem[r] = '0; pend[r] = 0; end
    clr_left = DEPTH;
    idleInputs();
    rst = 1;
    reset = 1; clear_req = 0; wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 0; issue_addr = '0; rd_addr = '0;
    @(posedge clock); #1;

    $display("[TB] reset and initial clear sweep");
    for (int p = 0; p < NRD; p++) ra[p] = AW'(p + 9);
    step();
    rst = 0;
    for (int k = 1; k < DEPTH; k++) step();
    checkOutput("t1 ready after 31", {31'b0, ready}, 32'd0);
    step();
    checkOutput("t1 ready after 32", {31'b0, ready}, 32'd1);

    $display("[TB] same-address write priority");
    idleInputs();
    we[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF;
    we[1] = 1; wa[1] = 5; wd[1] = 32'h12345678;
    step();
    idleInputs(); ra[0] = 5;
    applyStimulus();
    checkOutput("t2 x5", rd_data[0 +: DW], 32'h12345678);
    tick();

    $display("[TB] x0 hard-wired");
    idleInputs();
    we[1] = 1; wa[1] = 0; wd[1] = 32'hFFFFFFFF; iss = 1; iss_a = 0;
    step();
    idleInputs(); ra[2] = 0;
    applyStimulus();
    checkOutput("t3 x0 data", rd_data[2*DW +: DW], 32'd0);
    checkOutput("t3 x0 pend", {31'b0, rd_pending[2]}, 32'd0);
    tick();

    $display("[TB] scoreboard issue/writeback");
    idleInputs(); iss = 1; iss_a = 7;
    step();
    idleInputs(); ra[1] = 7;
    applyStimulus();
    checkOutput("t4 x7 pending", {31'b0, rd_pending[1]}, 32'd1);
    tick();
    idleInputs(); we[0] = 1; wa[0] = 7; wd[0] = 32'h55; iss = 1; iss_a = 7;
    step();
    idleInputs(); ra[1] = 7;
    applyStimulus();
    checkOutput("t4 x7 still pending", {31'b0, rd_pending[1]}, 32'd1);
    checkOutput("t4 x7 data", rd_data[DW +: DW], 32'h55);
    tick();

    $display("[TB] write/read same cycle");
    idleInputs(); we[0] = 1; wa[0] = 3; wd[0] = 32'h11;
    step();
    idleInputs(); we[1] = 1; wa[1] = 3; wd[1] = 32'hA5A5A5A5; ra[3] = 3;
    applyStimulus();
`ifdef RF_BYPASS_EN
    checkOutput("t5 x3 same cycle", rd_data[3*DW +: DW], 32'hA5A5A5A5);
`else
    checkOutput("t5 x3 same cycle", rd_data[3*DW +: DW], 32'h11);
`endif
    tick();
    idleInputs(); ra[3] = 3;
    applyStimulus();
    checkOutput("t5 x3 next cycle", rd_data[3*DW +: DW], 32'hA5A5A5A5);
    tick();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      idleInputs();
      clr = ($urandom_range(0, 79) == 0);
      iss = $urandom_range(0, 1) == 1;
      iss_a = AW'($urandom_range(0, 11));
      for (int i = 0; i < NWR; i++) begin
        we[i] = $urandom_range(0, 2) != 0;
        wa[i] = AW'($urandom_range(0, 11));
        wd[i] = $urandom;
      end
      for (int p = 0; p < NRD; p++)
        ra[p] = ($urandom_range(0, 2) == 0) ? wa[p % NWR] : AW'($urandom_range(0, 31));
      step();
    end
    idleInputs();
    while (clr_left > 0) step();

    $display("[TB] clear request and reset mid-clear");
    idleInputs(); we[0] = 1; wa[0] = 10; wd[0] = 32'h2A;
    step();
    idleInputs();
    applyStimulus();
    checkOutput("t6 a0 written", a0_value, 32'h2A);
    tick();
    clr = 1;
    step();
    clr = 0;
    for (int k = 1; k < DEPTH; k++) step();
    checkOutput("t6 a0 cleared", a0_value, 32'd0);
    step();
    checkOutput("t6 ready after clear", {31'b0, ready}, 32'd1);
    clr = 1;
    step();
    clr = 0;
    for (int k = 0; k < 10; k++) step();
    rst = 1;
    step();
    rst = 0;
    for (int k = 1; k < DEPTH; k++) step();
    checkOutput("t6 ready 31 after mid reset", {31'b0, ready}, 32'd0);
    step();
    checkOutput("t6 ready 32 after mid reset", {31'b0, ready}, 32'd1);
    for (int p = 0; p < NRD; p++) ra[p] = AW'(p + 3);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
